// File: rtl/l2_arb_ctrl_if.sv
// Request, lookup, fill and memory-read signals of the L2 arbiter/controller.
// The master modport is the controller's view; slave is the view of its environment.
interface l2_arb_ctrl_if #(
    parameter int ADDR_SIZE = 32,
    parameter int DATA_SIZE = 32,
    parameter int WAY_VALUE = 8
);
    localparam int WB = (WAY_VALUE > 1) ? $clog2(WAY_VALUE) : 1;

    logic                 req0_valid, req1_valid;
    logic [ADDR_SIZE-1:0] req0_addr, req1_addr;
    logic                 req0_ready, req1_ready;
    logic                 resp0_valid, resp1_valid;
    logic [DATA_SIZE-1:0] resp_data;
    logic                 lk_valid;
    logic [ADDR_SIZE-1:0] lk_addr;
    logic                 lk_hit;
    logic [DATA_SIZE-1:0] lk_data;
    logic [WB-1:0]        lk_way;
    logic                 fill_en;
    logic [WB-1:0]        fill_way;
    logic [ADDR_SIZE-1:0] fill_addr;
    logic [DATA_SIZE-1:0] fill_data;
    logic                 mem_rd_valid;
    logic [ADDR_SIZE-1:0] mem_rd_addr;
    logic                 mem_rd_ready;
    logic                 mem_rsp_valid;
    logic [DATA_SIZE-1:0] mem_rsp_data;
    logic                 busy;

    modport master (
        input  req0_valid, req1_valid, req0_addr, req1_addr,
               lk_hit, lk_data, lk_way, mem_rd_ready, mem_rsp_valid, mem_rsp_data,
        output req0_ready, req1_ready, resp0_valid, resp1_valid, resp_data,
               lk_valid, lk_addr, fill_en, fill_way, fill_addr, fill_data,
               mem_rd_valid, mem_rd_addr, busy
    );

    modport slave (
        output req0_valid, req1_valid, req0_addr, req1_addr,
               lk_hit, lk_data, lk_way, mem_rd_ready, mem_rsp_valid, mem_rsp_data,
        input  req0_ready, req1_ready, resp0_valid, resp1_valid, resp_data,
               lk_valid, lk_addr, fill_en, fill_way, fill_addr, fill_data,
               mem_rd_valid, mem_rd_addr, busy
    );
endinterface

// File: rtl/l2_arb_ctrl.sv
// Two-requester round-robin L2 read controller: lookup, miss fetch from memory, fill, respond.
// Define L2_ARB_CTRL_PERF_CNT_EN to add saturating hit_cnt/miss_cnt outputs.
module l2_arb_ctrl #(
    parameter int ADDR_SIZE = 32,
    parameter int DATA_SIZE = 32,
    parameter int WAY_VALUE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    l2_arb_ctrl_if.master        bus
`ifdef L2_ARB_CTRL_PERF_CNT_EN
    ,
    output logic [31:0]          hit_cnt,
    output logic [31:0]          miss_cnt
`endif
);
    localparam int WB = (WAY_VALUE > 1) ? $clog2(WAY_VALUE) : 1;

    typedef enum logic [2:0] {
        IDLE, LOOKUP, CHECK, MEM_REQ, MEM_WAIT, FILL, RESP
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_SIZE-1:0] addr_q;
    logic [DATA_SIZE-1:0] data_q;
    logic [DATA_SIZE-1:0] resp_q;
    logic [WB-1:0]        victim_q;
    logic                 gnt_q;
    logic                 last_q;
    logic                 any_req;
    logic                 grant;

    assign any_req = bus.req0_valid | bus.req1_valid;
    // On a tie the requester not served last wins; a lone requester always wins.
    assign grant   = (bus.req0_valid && bus.req1_valid) ? ~last_q : bus.req1_valid;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: default first so no path through this block leaves state_d unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (any_req) state_d = LOOKUP;
            LOOKUP:   state_d = CHECK;
            CHECK:    state_d = bus.lk_hit ? RESP : MEM_REQ;
            MEM_REQ:  if (bus.mem_rd_ready) state_d = MEM_WAIT;
            MEM_WAIT: if (bus.mem_rsp_valid) state_d = FILL;
            FILL:     state_d = RESP;
            RESP:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req0_ready   = 1'b0;
        bus.req1_ready   = 1'b0;
        bus.resp0_valid  = 1'b0;
        bus.resp1_valid  = 1'b0;
        bus.lk_valid     = 1'b0;
        bus.lk_addr      = '0;
        bus.fill_en      = 1'b0;
        bus.fill_way     = '0;
        bus.fill_addr    = '0;
        bus.fill_data    = '0;
        bus.mem_rd_valid = 1'b0;
        bus.mem_rd_addr  = '0;
        bus.busy         = (state_q != IDLE);
        case (state_q)
            IDLE: if (any_req && !rst) begin
                bus.req0_ready = ~grant;
                bus.req1_ready = grant;
            end
            LOOKUP: begin
                bus.lk_valid = 1'b1;
                bus.lk_addr  = addr_q;
            end
            MEM_REQ: begin
                bus.mem_rd_valid = 1'b1;
                bus.mem_rd_addr  = addr_q;
            end
            FILL: begin
                bus.fill_en   = 1'b1;
                bus.fill_way  = victim_q;
                bus.fill_addr = addr_q;
                bus.fill_data = data_q;
            end
            RESP: begin
                bus.resp0_valid = ~gnt_q;
                bus.resp1_valid = gnt_q;
            end
            default: ;
        endcase
    end

    assign bus.resp_data = resp_q;

    // NOTE: the datapath registers are reset too, since their reset values are observable outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= '0;
            data_q   <= '0;
            resp_q   <= '0;
            victim_q <= '0;
            gnt_q    <= 1'b0;
            last_q   <= 1'b1;
        end else begin
            case (state_q)
                IDLE: if (any_req) begin
                    addr_q <= grant ? bus.req1_addr : bus.req0_addr;
                    gnt_q  <= grant;
                    last_q <= grant;
                end
                CHECK: begin
                    if (bus.lk_hit) begin
                        data_q <= bus.lk_data;
                        resp_q <= bus.lk_data;
                    end else begin
                        victim_q <= bus.lk_way;
                    end
                end
                MEM_WAIT: if (bus.mem_rsp_valid) data_q <= bus.mem_rsp_data;
                // resp_data only changes as RESP is entered, so it holds between responses.
                FILL: resp_q <= data_q;
                default: ;
            endcase
        end
    end

`ifdef L2_ARB_CTRL_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state_q == CHECK) begin
            if (bus.lk_hit) begin
                if (hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
            end else begin
                if (miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_l2_arb_ctrl.sv
// Directed bench for l2_arb_ctrl: per-cycle vector table for a hit and a miss, then
// hand sequences for contention, busy blocking, reset abort and (optionally) perf counters.
module tb_l2_arb_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    l2_arb_ctrl_if #(.ADDR_SIZE(32), .DATA_SIZE(32), .WAY_VALUE(8)) bus ();

`ifdef L2_ARB_CTRL_PERF_CNT_EN
    logic [31:0] hit_cnt, miss_cnt;
    l2_arb_ctrl #(.ADDR_SIZE(32), .DATA_SIZE(32), .WAY_VALUE(8)) dut (
        .clk(clk), .rst(rst), .bus(bus), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt));
`else
    l2_arb_ctrl #(.ADDR_SIZE(32), .DATA_SIZE(32), .WAY_VALUE(8)) dut (
        .clk(clk), .rst(rst), .bus(bus));
`endif

    // ctl bits: {busy, req0_ready, req1_ready, lk_valid, mem_rd_valid, fill_en, resp0_valid, resp1_valid}
    typedef struct {
        bit        r0v, r1v;
        bit [31:0] addr;
        bit        hit;
        bit [31:0] lkd;
        bit [2:0]  way;
        bit        mrdy, mrsp;
        bit [31:0] md;
        bit [7:0]  ctl;
        bit [31:0] eaddr;
        bit [2:0]  eway;
        bit [31:0] efd;
        bit [31:0] erd;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(bit r0v, bit r1v, bit [31:0] addr, bit hit, bit [31:0] lkd,
                                bit [2:0] way, bit mrdy, bit mrsp, bit [31:0] md, bit [7:0] ctl,
                                bit [31:0] eaddr, bit [2:0] eway, bit [31:0] efd, bit [31:0] erd);
        vec_t v;
        v.r0v = r0v; v.r1v = r1v; v.addr = addr; v.hit = hit; v.lkd = lkd; v.way = way;
        v.mrdy = mrdy; v.mrsp = mrsp; v.md = md; v.ctl = ctl;
        v.eaddr = eaddr; v.eway = eway; v.efd = efd; v.erd = erd;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [7:0] ctl_now();
        return {bus.busy, bus.req0_ready, bus.req1_ready, bus.lk_valid,
                bus.mem_rd_valid, bus.fill_en, bus.resp0_valid, bus.resp1_valid};
    endfunction

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.req0_valid = 0; bus.req1_valid = 0; bus.req0_addr = '0; bus.req1_addr = '0;
        bus.lk_hit = 0; bus.lk_data = '0; bus.lk_way = '0;
        bus.mem_rd_ready = 0; bus.mem_rsp_valid = 0; bus.mem_rsp_data = '0;
    endtask

    task automatic do_reset();
        next_cycle();
        drive_idle();
        rst = 1;
        next_cycle();
        next_cycle();
        rst = 0;
    endtask

`ifdef L2_ARB_CTRL_PERF_CNT_EN
    task automatic run_txn(input bit who, input bit [31:0] addr, input bit hit);
        bit got;
        bus.req0_valid = !who; bus.req1_valid = who;
        bus.req0_addr = addr; bus.req1_addr = addr;
        bus.lk_hit = hit; bus.lk_data = addr ^ 32'hFFFF_0000; bus.lk_way = 3'd1;
        bus.mem_rd_ready = 1; bus.mem_rsp_valid = 1; bus.mem_rsp_data = addr;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            got = who ? bus.req1_ready : bus.req0_ready;
            next_cycle();
        end
        check("perf_accept", got, 1'b1);
        bus.req0_valid = 0; bus.req1_valid = 0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = bus.resp0_valid | bus.resp1_valid;
            next_cycle();
        end
        check("perf_resp", got, 1'b1);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit       seen, bad;
        int       grants[4];
        bit [2:0] pat;

        drive_idle();

        // Hit on requester 0, then a miss on requester 1 with mem_rd_ready two cycles late.
        vecs[0]  = mk(1,0,32'h40,   0,0,0,             0,0,0,             8'h40, 32'h0,    0,0,             32'h0);
        vecs[1]  = mk(0,0,0,        0,0,0,             0,0,0,             8'h90, 32'h40,   0,0,             32'h0);
        vecs[2]  = mk(0,0,0,        1,32'hDEADBEEF,3,  0,0,0,             8'h80, 32'h0,    0,0,             32'h0);
        vecs[3]  = mk(0,0,0,        0,0,0,             0,0,0,             8'h82, 32'h0,    0,0,             32'hDEADBEEF);
        vecs[4]  = mk(0,0,0,        1,32'hCAFEF00D,0,  1,1,32'hAAAA5555,  8'h00, 32'h0,    0,0,             32'hDEADBEEF);
        vecs[5]  = mk(0,1,32'h1230, 0,0,0,             0,0,0,             8'h20, 32'h0,    0,0,             32'hDEADBEEF);
        vecs[6]  = mk(0,0,0,        0,0,0,             0,1,32'h1111,      8'h90, 32'h1230, 0,0,             32'hDEADBEEF);
        vecs[7]  = mk(0,0,0,        0,0,5,             0,0,0,             8'h80, 32'h0,    0,0,             32'hDEADBEEF);
        vecs[8]  = mk(0,0,0,        0,0,0,             0,0,0,             8'h88, 32'h1230, 0,0,             32'hDEADBEEF);
        vecs[9]  = mk(0,0,0,        0,0,0,             0,0,0,             8'h88, 32'h1230, 0,0,             32'hDEADBEEF);
        vecs[10] = mk(0,0,0,        0,0,0,             1,0,0,             8'h88, 32'h1230, 0,0,             32'hDEADBEEF);
        vecs[11] = mk(0,0,0,        0,0,0,             0,0,0,             8'h80, 32'h0,    0,0,             32'hDEADBEEF);
        vecs[12] = mk(0,0,0,        1,32'h9999,0,      0,1,32'h12345678,  8'h80, 32'h0,    0,0,             32'hDEADBEEF);
        vecs[13] = mk(0,0,0,        0,0,0,             0,0,0,             8'h84, 32'h1230, 5,32'h12345678,  32'hDEADBEEF);
        vecs[14] = mk(0,0,0,        0,0,0,             0,0,0,             8'h81, 32'h0,    0,0,             32'h12345678);
        vecs[15] = mk(0,0,0,        0,0,0,             0,0,0,             8'h00, 32'h0,    0,0,             32'h12345678);

        // Reset state, observed while rst is still high.
        rst = 1;
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("reset_ctl", ctl_now(), 8'h00);
        check("reset_resp_data", bus.resp_data, 32'h0);
        next_cycle();
        rst = 0;

        for (int i = 0; i < 16; i++) begin
            if (i > 0) next_cycle();
            bus.req0_valid = vecs[i].r0v; bus.req1_valid = vecs[i].r1v;
            bus.req0_addr = vecs[i].addr; bus.req1_addr = vecs[i].addr;
            bus.lk_hit = vecs[i].hit; bus.lk_data = vecs[i].lkd; bus.lk_way = vecs[i].way;
            bus.mem_rd_ready = vecs[i].mrdy; bus.mem_rsp_valid = vecs[i].mrsp;
            bus.mem_rsp_data = vecs[i].md;
            @(negedge clk);
            check($sformatf("vec%0d_ctl", i), ctl_now(), vecs[i].ctl);
            check($sformatf("vec%0d_addr", i), bus.lk_addr | bus.mem_rd_addr | bus.fill_addr, vecs[i].eaddr);
            check($sformatf("vec%0d_fill_way", i), bus.fill_way, vecs[i].eway);
            check($sformatf("vec%0d_fill_data", i), bus.fill_data, vecs[i].efd);
            check($sformatf("vec%0d_resp_data", i), bus.resp_data, vecs[i].erd);
        end

        // Contention: both requesters held valid from reset; grants must alternate 0,1,0,1.
        do_reset();
        bus.req0_valid = 1; bus.req1_valid = 1;
        bus.req0_addr = 32'hA0; bus.req1_addr = 32'hB0;
        bus.lk_hit = 1; bus.lk_data = 32'h5A5A5A5A;
        bad = 0;
        for (int g = 0; g < 4; g++) begin
            grants[g] = -1;
            for (int c = 0; c < 10 && grants[g] < 0; c++) begin
                @(negedge clk);
                if (bus.req0_ready && bus.req1_ready) bad = 1;
                if (bus.req0_ready) grants[g] = 0;
                else if (bus.req1_ready) grants[g] = 1;
                next_cycle();
            end
        end
        check("contention_double_ready", bad, 1'b0);
        for (int g = 0; g < 4; g++)
            check($sformatf("contention_grant%0d", g), grants[g], g % 2);

        // Busy: req1 arrives during a req0 miss and must wait until IDLE.
        do_reset();
        drive_idle();
        bus.req0_valid = 1; bus.req0_addr = 32'h80; bus.lk_way = 3'd2;
        @(negedge clk);
        check("busy_accept0", bus.req0_ready, 1'b1);
        next_cycle();
        bus.req0_valid = 0; bus.req1_valid = 1; bus.req1_addr = 32'h90;
        bad = 0; seen = 0;
        for (int c = 0; c < 30 && !seen; c++) begin
            if (c >= 4) bus.mem_rd_ready = 1;
            if (c >= 7) begin bus.mem_rsp_valid = 1; bus.mem_rsp_data = 32'h77; end
            @(negedge clk);
            if (bus.busy) begin
                if (bus.req1_ready) bad = 1;
            end else begin
                seen = 1;
                check("busy_idle_grant1", bus.req1_ready, 1'b1);
            end
            if (!seen) next_cycle();
        end
        check("busy_no_early_ready", bad, 1'b0);
        check("busy_returned_idle", seen, 1'b1);

        // Reset during MEM_WAIT aborts with no fill or response; a late memory return is ignored.
        do_reset();
        drive_idle();
        bus.req0_valid = 1; bus.req0_addr = 32'h100; bus.mem_rd_ready = 1;
        @(negedge clk);
        check("rst_accept0", bus.req0_ready, 1'b1);
        next_cycle();
        bus.req0_valid = 0;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            seen = bus.mem_rd_valid;
            next_cycle();
        end
        check("rst_reached_mem_req", seen, 1'b1);
        @(negedge clk);
        check("rst_in_mem_wait", ctl_now(), 8'h80);
        next_cycle();
        rst = 1;
        next_cycle();
        rst = 0;
        bus.mem_rsp_valid = 1; bus.mem_rsp_data = 32'hBAD0BAD0;
        @(negedge clk);
        check("rst_abort_ctl", ctl_now(), 8'h00);
        check("rst_abort_resp_data", bus.resp_data, 32'h0);
        pat = 0;
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            @(negedge clk);
            pat[c] = |ctl_now();
        end
        check("rst_late_rsp_ignored", pat, 3'b000);

`ifdef L2_ARB_CTRL_PERF_CNT_EN
        do_reset();
        drive_idle();
        @(negedge clk);
        check("perf_reset_hit", hit_cnt, 32'd0);
        check("perf_reset_miss", miss_cnt, 32'd0);
        next_cycle();
        run_txn(0, 32'h200, 1);
        run_txn(1, 32'h204, 0);
        run_txn(0, 32'h208, 1);
        run_txn(1, 32'h20C, 1);
        run_txn(0, 32'h210, 0);
        @(negedge clk);
        check("perf_hit_cnt", hit_cnt, 32'd3);
        check("perf_miss_cnt", miss_cnt, 32'd2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
